sobel_line_buffer: RTL

SOBEL_LINE_BUFFER -- requirements
Module: sobel_line_buffer

---
 rtl/sobel_pkg.sv | 13 +
 rtl/sobel_line_delay.sv | 24 ++
 rtl/sobel_line_buffer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel line buffer: FSM state type and default geometry.
package sobel_pkg;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } lb_state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_IMG_W  = 640;
  localparam int DEF_IMG_H  = 480;

endpackage

// File: rtl/sobel_line_delay.sv
// One image line of storage, addressed by column; the read is combinational so the
// old entry is visible in the same cycle it gets overwritten.
module sobel_line_delay #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 640,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
  input  logic              clk,
  input  logic              en,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign dout = mem[addr];

  // Storage is never reset; every entry is rewritten before it is consumed.
  always_ff @(posedge clk) begin
    if (en) mem[addr] <= din;
  end

endmodule

// File: rtl/sobel_line_buffer.sv
// Three-row column generator for a 3x3 Sobel window; one-cycle registered latency.
// Define SOBEL_LB_FRAME_CNT_EN to add a 16-bit completed-frame counter output.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_i,
  input  logic              valid_i,
  input  logic              sof_i,
  output logic [DATA_W-1:0] d0_o,
  output logic [DATA_W-1:0] d1_o,
  output logic [DATA_W-1:0] d2_o,
  output logic              done_o,
  output logic              eof_o
`ifdef SOBEL_LB_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt_o
`endif
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  logic [COL_W-1:0]  col, col_eff, col_nxt;
  logic [ROW_W-1:0]  row, row_eff, row_nxt;
  lb_state_e         state, state_eff, state_nxt;
  logic [DATA_W-1:0] a_rd, b_rd;
  logic              col_end, frame_end, emit;

  // sof_i forces this pixel to (0,0) in FILL regardless of where the counters were.
  always_comb begin
    col_eff   = sof_i ? '0 : col;
    row_eff   = sof_i ? '0 : row;
    state_eff = sof_i ? FILL : state;
    col_end   = (col_eff == COL_LAST);
    frame_end = col_end && (row_eff == ROW_LAST);
    col_nxt   = col_end ? '0 : col_eff + 1'b1;
    row_nxt   = row_eff;
    if (col_end) row_nxt = frame_end ? '0 : row_eff + 1'b1;
    emit      = valid_i && (state_eff == STREAM);
  end

  always_comb begin
    state_nxt = state;
    if (valid_i) begin
      state_nxt = state_eff;
      case (state_eff)
        FILL:    if (col_end && row_eff == ROW_ONE) state_nxt = STREAM;
        STREAM:  if (frame_end)                     state_nxt = FILL;
        default: state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (valid_i) begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

  // Line A holds the previous line, line B the one before; B is refilled from A's old entry.
  sobel_line_delay #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(COL_W)) u_line_a (
    .clk  (clk),
    .en   (valid_i),
    .addr (col_eff),
    .din  (pix_i),
    .dout (a_rd)
  );

  sobel_line_delay #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(COL_W)) u_line_b (
    .clk  (clk),
    .en   (valid_i),
    .addr (col_eff),
    .din  (a_rd),
    .dout (b_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d0_o   <= '0;
      d1_o   <= '0;
      d2_o   <= '0;
      done_o <= 1'b0;
      eof_o  <= 1'b0;
    end else begin
      done_o <= emit;
      eof_o  <= valid_i && frame_end;
      if (emit) begin
        d0_o <= b_rd;
        d1_o <= a_rd;
        d2_o <= pix_i;
      end
    end
  end

`ifdef SOBEL_LB_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        frame_cnt_o <= '0;
    else if (valid_i && frame_end)  frame_cnt_o <= frame_cnt_o + 16'd1;
  end
`endif

endmodule
